// File: rtl/elevator_pkg.sv
// Shared elevator constants, direction encoding and hall-button bit mapping.
package elevator_pkg;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;
  localparam logic MOVE  = 1'b1;
  localparam logic HOLD  = 1'b0;

  localparam int unsigned NUM_FLOORS = 7;

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    DOWN   = 2'b01,
    UP     = 2'b10,
    UPDOWN = 2'b11
  } dir_e;

  // Floor n owns bits [2n-1:2n-2]: the upper bit is the up call.
  function automatic logic [3:0] hall_bit_index(input logic [2:0] floor, input dir_e dir);
    logic [3:0] base;
    base = {floor, 1'b0};
    return (dir == UP) ? base - 4'd1 : base - 4'd2;
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Synchronises raw button levels through SYNC_STAGES flops and flags rising edges.
module button_sync_edge #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sync = raw;
    end else begin : g_chain
      logic [WIDTH-1:0] stage [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= raw;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
      end

      assign sync = stage[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= sync;
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/request_latch.sv
// Latches hall and car button presses into request vectors and clears them as the car serves them.
// Define CAR_CANCEL_EN to let a re-press of a latched car button cancel it.
module request_latch
  import elevator_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_FLOORS  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] hallPress,
  input  logic [9:1]  carPress,
  input  logic [2:0]  currentFloor,
  input  logic [1:0]  currentDirection,
  input  logic        doorState,
  output logic [13:0] floorButton,
  output logic [9:1]  internalButton,
  output logic        stopHere
);

  localparam logic [2:0]  TOP_FLOOR  = 3'(NUM_FLOORS);
  localparam logic [13:0] HALL_LEGAL = 14'h1FFE;

  logic [13:0] hall_rise;
  logic [8:0]  car_rise;
  logic [7:1]  car_set;
  logic [7:1]  car_cancel;

  logic [13:0] hall_q;
  logic [7:1]  car_q;
  logic [1:0]  key_q;
  logic        stop_q;

  logic [13:0] hall_clr;
  logic [7:1]  car_clr;
  logic        stop_d;

  dir_e        dir;
  logic        floor_ok;
  logic [3:0]  up_idx;
  logic [3:0]  dn_idx;

  button_sync_edge #(.WIDTH(14), .SYNC_STAGES(SYNC_STAGES)) u_hall_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (hallPress),
    .rise  (hall_rise)
  );

  button_sync_edge #(.WIDTH(9), .SYNC_STAGES(SYNC_STAGES)) u_car_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (carPress),
    .rise  (car_rise)
  );

  assign dir      = dir_e'(currentDirection);
  assign floor_ok = (currentFloor != 3'd0) && (currentFloor <= TOP_FLOOR);
  assign up_idx   = hall_bit_index(currentFloor, UP);
  assign dn_idx   = hall_bit_index(currentFloor, DOWN);
  assign car_set  = car_rise[6:0];

`ifdef CAR_CANCEL_EN
  assign car_cancel = car_set & car_q;
`else
  assign car_cancel = '0;
`endif

  // UPDOWN falls into the default arm and clears like STOP.
  always_comb begin
    hall_clr = '0;
    car_clr  = '0;
    if (doorState == OPEN && floor_ok) begin
      car_clr[currentFloor] = ON;
      case (dir)
        UP:      hall_clr[up_idx] = ON;
        DOWN:    hall_clr[dn_idx] = ON;
        default: begin
          hall_clr[up_idx] = ON;
          hall_clr[dn_idx] = ON;
        end
      endcase
      if (currentFloor == 3'd1)      hall_clr[up_idx] = ON;
      if (currentFloor == TOP_FLOOR) hall_clr[dn_idx] = ON;
    end
  end

  // Evaluated on the pre-update vectors, so a fresh request shows one cycle later.
  always_comb begin
    stop_d = OFF;
    if (doorState != OPEN && floor_ok) begin
      case (dir)
        UP:      stop_d = car_q[currentFloor] | hall_q[up_idx];
        DOWN:    stop_d = car_q[currentFloor] | hall_q[dn_idx];
        default: stop_d = car_q[currentFloor] | hall_q[up_idx] | hall_q[dn_idx];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hall_q <= '0;
      car_q  <= '0;
      key_q  <= '0;
      stop_q <= OFF;
    end else begin
      hall_q <= (hall_q | (hall_rise & HALL_LEGAL)) & ~hall_clr;
      car_q  <= (car_q | car_set) & ~car_cancel & ~car_clr;
      key_q  <= car_rise[8:7];
      stop_q <= stop_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && dir == UPDOWN)
      $display("request_latch: currentDirection UPDOWN is illegal, handled as STOP");
  end
`endif

  assign floorButton    = hall_q;
  assign internalButton = {key_q, car_q};
  assign stopHere       = stop_q;

endmodule

// File: tb/tb_request_latch.sv
// Self-checking bench for request_latch against a per-floor behavioural model.
module tb_request_latch;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] hallPress;
  logic [9:1]  carPress;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic [13:0] floorButton;
  logic [9:1]  internalButton;
  logic        stopHere;

  int vectors = 0;
  int miscompares = 0;

  // Model: pending calls per floor, and a delay line of raw input samples.
  bit          m_up [1:7];
  bit          m_dn [1:7];
  bit          m_car[1:7];
  bit          m_k8, m_k9, m_stop;
  logic [22:0] hist [0:SYNC+1];

  request_latch #(.SYNC_STAGES(SYNC), .NUM_FLOORS(7)) dut (
    .clk              (clk),
    .reset            (reset),
    .hallPress        (hallPress),
    .carPress         (carPress),
    .currentFloor     (currentFloor),
    .currentDirection (currentDirection),
    .doorState        (doorState),
    .floorButton      (floorButton),
    .internalButton   (internalButton),
    .stopHere         (stopHere)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [22:0] rise;
    int f;
    bit valid, nstop;
    if (reset) begin
      for (int n = 1; n <= 7; n++) begin
        m_up[n] = 0; m_dn[n] = 0; m_car[n] = 0;
      end
      m_k8 = 0; m_k9 = 0; m_stop = 0;
      for (int i = 0; i <= SYNC + 1; i++) hist[i] = '0;
      return;
    end
    for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {carPress, hallPress};
    rise = hist[SYNC] & ~hist[SYNC+1];
    f = int'(currentFloor);
    valid = (f >= 1) && (f <= 7);
    nstop = 0;
    if (valid && !doorState) begin
      case (currentDirection)
        2'b10:   nstop = m_car[f] || m_up[f];
        2'b01:   nstop = m_car[f] || m_dn[f];
        default: nstop = m_car[f] || m_up[f] || m_dn[f];
      endcase
    end
    for (int n = 1; n <= 7; n++) begin
      if (n < 7 && rise[2*n-1]) m_up[n] = 1;
      if (n > 1 && rise[2*n-2]) m_dn[n] = 1;
      if (rise[13+n]) begin
`ifdef CAR_CANCEL_EN
        m_car[n] = !m_car[n];
`else
        m_car[n] = 1;
`endif
      end
    end
    if (valid && doorState) begin
      m_car[f] = 0;
      if (currentDirection != 2'b01 || f == 1) m_up[f] = 0;
      if (currentDirection != 2'b10 || f == 7) m_dn[f] = 0;
    end
    m_k8 = rise[21];
    m_k9 = rise[22];
    m_stop = nstop;
  endtask

  function automatic logic [13:0] exp_floor();
    logic [13:0] v;
    v = '0;
    for (int n = 1; n <= 7; n++) begin
      v[2*n-1] = m_up[n];
      v[2*n-2] = m_dn[n];
    end
    return v;
  endfunction

  function automatic logic [9:1] exp_int();
    logic [9:1] v;
    v = '0;
    for (int n = 1; n <= 7; n++) v[n] = m_car[n];
    v[8] = m_k8;
    v[9] = m_k9;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    hallPress = '0; carPress = '0; currentFloor = 3'd0;
    currentDirection = 2'b00; doorState = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hallPress = 14'($urandom); carPress = 9'($urandom);
    currentFloor = 3'($urandom); currentDirection = 2'($urandom); doorState = 1'($urandom);
    cycle();
    vectors++;
    if (floorButton !== 14'h0000) begin
      miscompares++; $display("FAIL reset_floor: got %h expected %h", floorButton, 14'h0000);
    end
    vectors++;
    if (internalButton !== 9'h000) begin
      miscompares++; $display("FAIL reset_internal: got %h expected %h", internalButton, 9'h000);
    end
    vectors++;
    if (stopHere !== 1'b0) begin
      miscompares++; $display("FAIL reset_stop: got %b expected 0", stopHere);
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_latency();
    logic [13:0] want [1:3];
    want[1] = 14'h0000; want[2] = 14'h0000; want[3] = 14'h0010;
    do_reset();
    hallPress[4] = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      hallPress = '0;
      vectors++;
      if (floorButton !== want[e]) begin
        miscompares++; $display("FAIL latency_edge%0d: got %h expected %h", e, floorButton, want[e]);
      end
    end
    repeat (5) cycle();
    vectors++;
    if (floorButton !== 14'h0010 || floorButton !== exp_floor()) begin
      miscompares++; $display("FAIL latency_hold: got %h expected %h", floorButton, 14'h0010);
    end
  endtask

  task automatic test_car_hold();
    do_reset();
    carPress[5] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      vectors++;
      if (internalButton !== exp_int()) begin
        miscompares++; $display("FAIL car_hold_c%0d: got %h expected %h", c, internalButton, exp_int());
      end
    end
    vectors++;
    if (internalButton !== 9'h010) begin
      miscompares++; $display("FAIL car_held: got %h expected %h", internalButton, 9'h010);
    end
    carPress = '0;
    repeat (3) cycle();
    carPress[5] = 1'b1;
    cycle();
    carPress = '0;
    repeat (4) cycle();
    vectors++;
`ifdef CAR_CANCEL_EN
    if (internalButton !== 9'h000 || internalButton !== exp_int()) begin
      miscompares++; $display("FAIL car_repress: got %h expected %h", internalButton, 9'h000);
    end
`else
    if (internalButton !== 9'h010 || internalButton !== exp_int()) begin
      miscompares++; $display("FAIL car_repress: got %h expected %h", internalButton, 9'h010);
    end
`endif
  endtask

  task automatic test_serve_direction();
    do_reset();
    hallPress[9:8] = 2'b11;
    cycle();
    hallPress = '0;
    repeat (3) cycle();
    vectors++;
    if (floorButton !== 14'h0300) begin
      miscompares++; $display("FAIL serve_latched: got %h expected %h", floorButton, 14'h0300);
    end
    currentFloor = 3'd5; currentDirection = 2'b10; doorState = 1'b0;
    cycle();
    vectors++;
    if (stopHere !== 1'b1 || stopHere !== m_stop) begin
      miscompares++; $display("FAIL serve_stophint: got %b expected 1", stopHere);
    end
    doorState = 1'b1;
    cycle();
    vectors++;
    if (floorButton !== 14'h0100 || floorButton !== exp_floor()) begin
      miscompares++; $display("FAIL serve_up: got %h expected %h", floorButton, 14'h0100);
    end
    vectors++;
    if (stopHere !== 1'b0) begin
      miscompares++; $display("FAIL serve_open_stop: got %b expected 0", stopHere);
    end
    currentDirection = 2'b01;
    cycle();
    vectors++;
    if (floorButton !== 14'h0000) begin
      miscompares++; $display("FAIL serve_down: got %h expected %h", floorButton, 14'h0000);
    end
    idle();
  endtask

  task automatic test_illegal_bits();
    do_reset();
    hallPress = 14'h2001;
    cycle();
    hallPress = '0;
    repeat (4) cycle();
    vectors++;
    if (floorButton !== 14'h0000 || floorButton !== exp_floor()) begin
      miscompares++; $display("FAIL illegal_bits: got %h expected %h", floorButton, 14'h0000);
    end
  endtask

  task automatic test_car_at_floor();
    do_reset();
    currentFloor = 3'd3; doorState = 1'b1; currentDirection = 2'b00;
    carPress[3] = 1'b1;
    repeat (4) cycle();
    vectors++;
    if (internalButton[3] !== 1'b0 || internalButton !== exp_int()) begin
      miscompares++; $display("FAIL car_at_floor: got %h expected %h", internalButton, 9'h000);
    end
    vectors++;
    if (stopHere !== 1'b0) begin
      miscompares++; $display("FAIL car_at_floor_stop: got %b expected 0", stopHere);
    end
    idle();
    cycle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    hallPress[3] = 1'b1; hallPress[10] = 1'b1;
    carPress[2] = 1'b1; carPress[6] = 1'b1;
    cycle();
    idle();
    repeat (3) cycle();
    vectors++;
    if (floorButton !== 14'h0408 || internalButton !== 9'h022) begin
      miscompares++;
      $display("FAIL midreset_latched: got %h/%h expected %h/%h", floorButton, internalButton, 14'h0408, 9'h022);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    vectors++;
    if (floorButton !== 14'h0000 || internalButton !== 9'h000 || stopHere !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_clear: got %h/%h/%b expected 0000/000/0", floorButton, internalButton, stopHere);
    end
    hallPress[5] = 1'b1;
    cycle();
    hallPress = '0;
    repeat (2) cycle();
    vectors++;
    if (floorButton !== 14'h0020) begin
      miscompares++; $display("FAIL midreset_relatch: got %h expected %h", floorButton, 14'h0020);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hallPress ^= 14'($urandom & $urandom & $urandom);
      carPress  ^= 9'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) currentFloor = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        currentDirection = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) doorState = ~doorState;
      reset = ($urandom_range(0, 149) == 0);
      cycle();
      vectors++;
      if (floorButton !== exp_floor()) begin
        miscompares++; $display("FAIL rand_floor_c%0d: got %h expected %h", c, floorButton, exp_floor());
      end
      vectors++;
      if (internalButton !== exp_int()) begin
        miscompares++; $display("FAIL rand_internal_c%0d: got %h expected %h", c, internalButton, exp_int());
      end
      vectors++;
      if (stopHere !== m_stop) begin
        miscompares++; $display("FAIL rand_stop_c%0d: got %b expected %b", c, stopHere, m_stop);
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_latency();
    test_car_hold();
    test_serve_direction();
    test_illegal_bits();
    test_car_at_floor();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
